btn_conditioner: RTL and testbench

- Per-button input conditioner that sits directly upstream of the digit-entry/GCD controller.
- Converts a raw, asynchronous, bouncing push-button or key signal into a clean level and single-cycle event pulses.
- The `add` and `next` inputs of the controller are driven from its `btn_rise` (or `btn_repeat`) outputs.
- One instance per physical button.

---
 rtl/btn_conditioner.sv | 187 ++++++++++++++++++
 tb/tb_btn_conditioner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button input conditioner.
// Turns a raw, asynchronous, bouncing button level into a clean debounced
// level plus single-cycle press/release pulses, with optional auto-repeat.
// Optional feature macro: BTN_AUTOREPEAT_EN. When it is defined, btn_repeat
// pulses while the button is held. Otherwise btn_repeat is tied to 0.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_repeat
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic RELEASED_RAW = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  // Parameter values that would make the counters meaningless are stopped at elaboration
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic             sync_q1;
  logic             sync_q2;
  logic             p;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  // Two-flop synchroniser; reset loads the released raw level so no false press appears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= RELEASED_RAW;
      sync_q2 <= RELEASED_RAW;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  assign p = (sync_q2 != RELEASED_RAW);

  // State register, debounce counter and registered level/pulse outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RELEASED;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= level_nxt;
      btn_rise  <= rise_nxt;
      btn_fall  <= fall_nxt;
    end
  end

  // Next-state logic: a change is accepted only after it has been stable long enough.
  // The counter never exceeds CNT_MAX, so it cannot wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RELEASED: begin
        if (p) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_MAX) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_MAX) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: pulses only on completed debounce transitions, never on bounce-backs
  always_comb begin
    rise_nxt  = (state == PRESS_WAIT) && (state_nxt == PRESSED);
    fall_nxt  = (state == RELEASE_WAIT) && (state_nxt == RELEASED);
    level_nxt = btn_level;
    if (rise_nxt) begin
      level_nxt = 1'b1;
    end else if (fall_nxt) begin
      level_nxt = 1'b0;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_nxt;
  logic [RPT_W-1:0] rpt_inc;
  logic             repeat_nxt;

  assign rpt_inc = rpt_cnt + RPT_W'(1);

  // Repeat counter: counts while held stable in PRESSED, holds during a release bounce.
  // After the first pulse it folds back to RPT_FIRST every period, so it never wraps.
  always_comb begin
    rpt_cnt_nxt = rpt_cnt;
    repeat_nxt  = 1'b0;
    if (state_nxt == RELEASED || state == PRESS_WAIT) begin
      rpt_cnt_nxt = '0;
    end else if (state == PRESSED && state_nxt == PRESSED) begin
      if (rpt_inc == RPT_FIRST) begin
        repeat_nxt  = 1'b1;
        rpt_cnt_nxt = rpt_inc;
      end else if (rpt_inc == RPT_NEXT) begin
        repeat_nxt  = 1'b1;
        rpt_cnt_nxt = RPT_FIRST;
      end else begin
        rpt_cnt_nxt = rpt_inc;
      end
    end
  end

  // Repeat counter and registered repeat pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_cnt    <= '0;
      btn_repeat <= 1'b0;
    end else begin
      rpt_cnt    <= rpt_cnt_nxt;
      btn_repeat <= repeat_nxt;
    end
  end
`else
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus randomized button traffic,
// checked every cycle against a run-length reference model of the debouncer.
// With BTN_AUTOREPEAT_EN defined, the auto-repeat timing is checked as well.
module tb_btn_conditioner;

  localparam int D  = 4;
  localparam int RD = 6;
  localparam int RP = 3;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic btn_repeat;

  int total;
  int bad;
  int edge_idx;

  // reference model state
  logic m_d1;
  logic m_d2;
  logic m_level;
  int   m_run;
  int   m_age;
  logic exp_rise;
  logic exp_fall;
  logic exp_rep;

  // per-scenario tallies of what the DUT produced
  int rise_cnt;
  int fall_cnt;
  int rep_cnt;
  int level_hits;
  int first_rise;
  int first_fall;
  int rep_edges[$];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .BTN_ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_repeat(btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, edge_idx, got, expv);
    end
  endtask

  task automatic clearTally();
    rise_cnt   = 0;
    fall_cnt   = 0;
    rep_cnt    = 0;
    level_hits = 0;
    first_rise = -1;
    first_fall = -1;
    rep_edges.delete();
    edge_idx   = 0;
  endtask

  // Drives one clock cycle (called just after a falling edge), advances the
  // model by one rising edge and compares every output half a cycle later.
  task automatic applyStimulus(input logic rst_v, input logic btn_v);
    logic pressed;
    logic stable_held;
    rst_n  = rst_v;
    btn_in = btn_v;
    exp_rise = 1'b0;
    exp_fall = 1'b0;
    exp_rep  = 1'b0;
    if (!rst_v) begin
      m_d1    = 1'b1;
      m_d2    = 1'b1;
      m_level = 1'b0;
      m_run   = 0;
      m_age   = 0;
    end else begin
      pressed     = (m_d2 == 1'b0);
      m_d2        = m_d1;
      m_d1        = btn_v;
      stable_held = m_level && (m_run == 0);
      if (pressed != m_level) m_run = m_run + 1;
      else m_run = 0;
      if (m_run == D + 1) begin
        m_level = ~m_level;
        m_run   = 0;
        m_age   = 0;
        if (m_level) exp_rise = 1'b1;
        else exp_fall = 1'b1;
      end else if (stable_held && pressed) begin
        m_age = m_age + 1;
        if (m_age == RD || (m_age > RD && ((m_age - RD) % RP) == 0)) exp_rep = 1'b1;
      end
    end
`ifndef BTN_AUTOREPEAT_EN
    exp_rep = 1'b0;
`endif
    @(posedge clk);
    edge_idx++;
    @(negedge clk);
    checkOutput("level", btn_level, m_level);
    checkOutput("rise", btn_rise, exp_rise);
    checkOutput("fall", btn_fall, exp_fall);
    checkOutput("repeat", btn_repeat, exp_rep);
    if (btn_rise && btn_fall) checkOutput("rise_fall_excl", 1, 0);
    if (btn_rise) begin
      rise_cnt++;
      if (first_rise < 0) first_rise = edge_idx;
    end
    if (btn_fall) begin
      fall_cnt++;
      if (first_fall < 0) first_fall = edge_idx;
    end
    if (btn_repeat) begin
      rep_cnt++;
      rep_edges.push_back(edge_idx);
    end
    if (btn_level) level_hits++;
  endtask

  initial begin
    int seg_len;
    logic lvl;
    total    = 0;
    bad      = 0;
    edge_idx = 0;
    rst_n    = 1'b0;
    btn_in   = 1'b1;
    m_d1     = 1'b1;
    m_d2     = 1'b1;
    m_level  = 1'b0;
    m_run    = 0;
    m_age    = 0;
    @(negedge clk);

    // Scenario 1: reset with button released, then idle
    clearTally();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("s1_quiet", rise_cnt + fall_cnt + rep_cnt + level_hits, 0);

    // Scenario 2: press and long hold
    clearTally();
    for (int i = 0; i < 107; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("s2_rise_edge", first_rise, D + 3);
    checkOutput("s2_rise_count", rise_cnt, 1);
    checkOutput("s2_no_fall", fall_cnt, 0);

    // Scenario 4: release and hold released
    clearTally();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("s4_fall_edge", first_fall, D + 3);
    checkOutput("s4_fall_count", fall_cnt, 1);
    checkOutput("s4_level_low", btn_level, 0);

    // Scenario 3: short press glitches while idle, then a release glitch while pressed
    clearTally();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
    end
    checkOutput("s3_idle_no_rise", rise_cnt, 0);
    checkOutput("s3_idle_level", level_hits, 0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0);
    clearTally();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("s3_held_no_fall", fall_cnt, 0);
    checkOutput("s3_held_level", level_hits, 15);

    // Scenario 5: reset in the middle of a held press
    clearTally();
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("s5_reset_quiet", rise_cnt + fall_cnt + level_hits, 0);
    clearTally();
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("s5_rise_edge", first_rise, D + 3);
    checkOutput("s5_no_fall", fall_cnt, 0);

`ifdef BTN_AUTOREPEAT_EN
    // Scenario 6: auto-repeat timing while held, silence after release
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1);
    clearTally();
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("s6_rep_count_min", (rep_edges.size() >= 3) ? 1 : 0, 1);
    if (rep_edges.size() >= 3) begin
      checkOutput("s6_rep1", rep_edges[0] - first_rise, RD);
      checkOutput("s6_rep2", rep_edges[1] - first_rise, RD + RP);
      checkOutput("s6_rep3", rep_edges[2] - first_rise, RD + 2 * RP);
    end
    for (int i = 0; i < D + 3; i++) applyStimulus(1'b1, 1'b1);
    clearTally();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("s6_no_rep_after_release", rep_cnt, 0);
`else
    checkOutput("repeat_tied_low", btn_repeat, 0);
`endif

    // Randomized traffic: runs of random length, occasional reset
    clearTally();
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 2)); i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      end
      lvl = 1'($urandom_range(0, 1));
      seg_len = (s % 10 == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 9));
      for (int i = 0; i < seg_len; i++) applyStimulus(1'b1, lvl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
